// File: rtl/spwm_modulator.sv
// Three-phase sine-triangle PWM modulator: shared symmetric carrier, regular-sampled
// references and an independent dead-time FSM per inverter leg.

module spwm_leg #(
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       raw_i,
  output logic       hi_o,
  output logic       lo_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } leg_state_e;

  localparam logic [7:0] CNT_RELOAD = 8'(DEAD_CYCLES - 1);

  leg_state_e state_q, state_d;
  logic       target_q, target_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hi_q, lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      cnt_q    <= 8'd0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      // Gate flops are loaded from the same next state, so hi and lo can never both be set.
      hi_q     <= (state_d == HIGH);
      lo_q     <= (state_d == LOW);
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = DEAD;
          target_d = raw_i;
          cnt_d    = CNT_RELOAD;
        end
        DEAD: begin
          // A demand change inside the dead band restarts it, swallowing narrow pulses.
          if (raw_i != target_q) begin
            target_d = raw_i;
            cnt_d    = CNT_RELOAD;
          end else if (cnt_q == 8'd0) begin
            state_d = target_q ? HIGH : LOW;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        HIGH: begin
          if (!raw_i) begin
            state_d  = DEAD;
            target_d = 1'b0;
            cnt_d    = CNT_RELOAD;
          end
        end
        LOW: begin
          if (raw_i) begin
            state_d  = DEAD;
            target_d = 1'b1;
            cnt_d    = CNT_RELOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

module spwm_modulator #(
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] mod_a,
  input  logic [7:0] mod_b,
  input  logic [7:0] mod_c,
  output logic [7:0] carrier,
  output logic       sync,
  output logic       a_hi,
  output logic       a_lo,
  output logic       b_hi,
  output logic       b_lo,
  output logic       c_hi,
  output logic       c_lo,
  output logic [5:0] dbg_state_o
);

  logic [7:0] carrier_q, carrier_d;
  logic       dir_down_q, dir_down_d;
  logic [7:0] ref_a_q, ref_b_q, ref_c_q;
  logic       sync_q;
  logic       at_valley;
  logic       raw_a, raw_b, raw_c;
  logic [1:0] st_a, st_b, st_c;

  assign at_valley = (carrier_q == 8'd0);

  // Triangle 0..255..1 with each peak value visited once: 510-cycle period.
  always_comb begin
    carrier_d  = carrier_q;
    dir_down_d = dir_down_q;
    if (!dir_down_q) begin
      if (carrier_q == 8'd255) begin
        carrier_d  = 8'd254;
        dir_down_d = 1'b1;
      end else begin
        carrier_d = carrier_q + 8'd1;
      end
    end else begin
      if (carrier_q == 8'd0) begin
        carrier_d  = 8'd1;
        dir_down_d = 1'b0;
      end else begin
        carrier_d = carrier_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q  <= 8'd0;
      dir_down_q <= 1'b0;
      ref_a_q    <= 8'd0;
      ref_b_q    <= 8'd0;
      ref_c_q    <= 8'd0;
      sync_q     <= 1'b0;
    end else begin
      carrier_q  <= carrier_d;
      dir_down_q <= dir_down_d;
      sync_q     <= at_valley;
      // Regular symmetric sampling: references only move at the carrier valley.
      if (at_valley) begin
        ref_a_q <= mod_a;
        ref_b_q <= mod_b;
        ref_c_q <= mod_c;
      end
    end
  end

  assign raw_a = (ref_a_q > carrier_q);
  assign raw_b = (ref_b_q > carrier_q);
  assign raw_c = (ref_c_q > carrier_q);

  spwm_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .raw_i    (raw_a),
    .hi_o     (a_hi),
    .lo_o     (a_lo),
    .state_o  (st_a)
  );

  spwm_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .raw_i    (raw_b),
    .hi_o     (b_hi),
    .lo_o     (b_lo),
    .state_o  (st_b)
  );

  spwm_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_c (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .raw_i    (raw_c),
    .hi_o     (c_hi),
    .lo_o     (c_lo),
    .state_o  (st_c)
  );

  assign carrier     = carrier_q;
  assign sync        = sync_q;
  assign dbg_state_o = {st_c, st_b, st_a};

endmodule

// File: doc/spwm_modulator.md
# spwm_modulator

Three-phase sine-triangle PWM modulator with dead-time insertion. Consumes the three 8-bit phase references produced by the three-phase sine generator. Compares each reference against a shared 8-bit symmetric triangular carrier. Drives complementary high/low gate signals per inverter leg, with a guaranteed both-off interval at every commutation.

## Interface

- DEAD_CYCLES, 8: length of the both-off interval in clk cycles; legal range 1..255.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  gate enable; low forces all gates off.
- mod_a  in  8  phase A reference, unsigned, 0..255.
- mod_b  in  8  phase B reference, unsigned.
- mod_c  in  8  phase C reference, unsigned.
- carrier  out  8  current triangular carrier value.
- sync  out  1  one-cycle pulse marking the first cycle in which newly latched references are in effect.
- a_hi, a_lo  out  1 each  phase A upper/lower gate.
- b_hi, b_lo  out  1 each  phase B upper/lower gate.
- c_hi, c_lo  out  1 each  phase C upper/lower gate.

## Operation

- **Carrier**
  - 8-bit register plus direction bit.
  - Counts 0,1,…,255, then 254,…,1, then 0,1,… continuously. Period is 510 cycles.
  - 0 and 255 each occur once per period.
  - Runs regardless of enable.
- **Reference latch**
  - Internal ref_a/b/c load mod_a/b/c at the rising edge that ends the cycle in which carrier==0. This is regular symmetric sampling.
  - Refs are held for the whole period. mod_x changes at any other time have no effect until the next valley.
  - The refs load independent of enable.
- **sync**
  - Registered. High exactly in the cycle after a load, i.e. carrier==1 on the up-count.
- **Demand**
  - raw_x = (ref_x > carrier), unsigned strict compare, combinational from registers.
  - ref=0 gives raw always 0.
  - ref=255 gives raw 0 only when carrier==255.
- **Per-phase FSM** (identical, independent per phase): registered target bit and 8-bit cnt.
  - **IDLE**: both gates 0. If enable, go to DEAD with target=raw and cnt=DEAD_CYCLES-1.
  - **DEAD**: both gates 0.
    - If raw≠target: target=raw, cnt=DEAD_CYCLES-1 (restart).
    - Else if cnt==0: go to HIGH if target=1, LOW if target=0.
    - Else cnt decrements.
  - **HIGH**: x_hi=1, x_lo=0. If raw==0: go to DEAD with target=0 and cnt=DEAD_CYCLES-1.
  - **LOW**: x_lo=1, x_hi=0. If raw==1: go to DEAD with target=1 and cnt=DEAD_CYCLES-1.
  - **enable=0** in any state: go to IDLE at the next edge. This has priority over all other transitions.
- Gate outputs are registered, decoded from the state register.
- x_hi and x_lo are never 1 simultaneously, in any state, including during reset entry and exit.
- **Narrow pulses**: a demand pulse shorter than the dead time restarts DEAD. The opposite gate never asserts for it.

## Timing

- **Reset** (asynchronous, immediate), all registers:
  - carrier=0, direction=up
  - ref_a/b/c=0
  - sync=0
  - all FSMs IDLE, cnt=0
  - all six gates 0
- **After rst falls**:
  - cycle 0: carrier=0.
  - cycle 1: carrier=1, sync=1, refs valid.
  - Further sync pulses at cycles 511, 1021, …
- **Commutation**, raw changes in cycle n while in HIGH or LOW:
  - active gate falls at cycle n+1;
  - both gates low for cycles n+1..n+DEAD_CYCLES;
  - opposite gate rises at cycle n+DEAD_CYCLES+1.
- **Demand blip**, raw toggles for one cycle n while in HIGH/LOW: the gate is off for cycles n+1..n+DEAD_CYCLES+1 (DEAD_CYCLES+1 cycles), then the original gate reasserts.
- **Enable**:
  - fall in cycle n: gates 0 from cycle n+1.
  - rise in cycle m: gates 0 through m+DEAD_CYCLES; the matching gate asserts at m+DEAD_CYCLES+1.
- **rst asserted mid-operation**: gates drop asynchronously; nothing is carried over.

## Test plan

- **Reset/carrier**
  - Stimulus: assert rst with enable=1, then release.
  - Required: all gates 0 and carrier=0 while rst is high.
  - Carrier sequence 0,1,…,255,254,…,0 with period 510.
  - sync high only at cycles 1, 511, 1021.
- **Mid-scale**
  - Stimulus: DEAD_CYCLES=8, mod_a=128, enable=1.
  - Required: raw_a=1 for carrier 0..127.
  - Every a_hi↔a_lo transition shows exactly 8 cycles with both low; never both high.
- **Extremes**
  - Stimulus: mod_b=0, then mod_b=255.
  - Required with mod_b=0: b_lo continuously high after the initial 8-cycle dead.
  - Required with mod_b=255: b_hi high except a 9-cycle gap around carrier==255; b_lo never asserts.
- **Sampling hold**
  - Stimulus: change mod_c from 50 to 200 while carrier=100 on the up-count.
  - Required: c duty unchanged until the edge after the next carrier==0; new duty applies from the following sync cycle.
- **Enable**
  - Stimulus: drop enable mid-HIGH, then restore it.
  - Required: all gates 0 the next cycle; after restore, 8 both-low cycles, then the gate matching raw.
- **Async reset mid-run**
  - Stimulus: pulse rst between clock edges while all phases are switching.
  - Required: gates 0 immediately, without waiting for a clock edge; the sequence restarts as in the first scenario.
